// File: rtl/axi_pkg.sv
// Shared widths, bus types and FSM encoding for the two-master AXI read arbiter.
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDM_W  = 4;
  localparam int IDS_W  = 8;
  localparam int MIDX_W = IDS_W - IDM_W;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Slave-side ID: master index in the upper nibble, master ID below it.
  function automatic logic [IDS_W-1:0] mk_sid(input logic g, input logic [IDM_W-1:0] id);
    return {MIDX_W'(g), id};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read channel bundle (AR + R); ID width is chosen per instance
// (master side IDM_W, slave side IDS_W).
interface axi_rd_arbiter_if #(
  parameter int ID_W = 4
);
  import axi_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  burst_t            arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/arb_grant2.sv
// Two-way request arbiter giving a one-hot grant. Define ARB_RR_EN for round-robin
// on ties (uses i_last_g); default is fixed priority with req[1] over req[0].
module arb_grant2 (
  input  logic [1:0] i_req,
`ifdef ARB_RR_EN
  input  logic       i_last_g,
`endif
  output logic [1:0] o_gnt
);

  always_comb begin
`ifdef ARB_RR_EN
    // On a tie the master that did not win last time goes next.
    o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last_g);
    o_gnt[0] = i_req[0] & (~i_req[1] |  i_last_g);
`else
    o_gnt[1] = i_req[1];
    o_gnt[0] = i_req[0] & ~i_req[1];
`endif
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port between M0 (fetch) and M1 (load), one transaction in flight, R steered by grant.
// Define ARB_RR_EN for round-robin arbitration on ties; default build gives M1 fixed priority.
module axi_rd_arbiter
  import axi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  axi_rd_arbiter_if.slave  m0_if,
  axi_rd_arbiter_if.slave  m1_if,
  axi_rd_arbiter_if.master s_if,
  output logic             o_prot_err
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;

  logic              r_g;
  logic [IDM_W-1:0]  r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [3:0]        r_arlen;
  logic [2:0]        r_arsize;
  burst_t            r_arburst;
  logic [3:0]        r_beat_cnt;
  logic              r_prot_err;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_grant;
  logic              w_sel;
  logic              w_rready_g;
  logic              w_beat;
  logic              w_err_last;
  logic              w_err_id;

  // Requests are only considered in IDLE, which also enforces the turnaround cycle.
  assign w_req = (r_state == IDLE) ? {m1_if.arvalid, m0_if.arvalid} : 2'b00;

`ifdef ARB_RR_EN
  logic r_last_g;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_g <= MST_M0;
    end else if (w_grant) begin
      r_last_g <= w_gnt[1];
    end
  end
`endif

  arb_grant2 u_grant (
    .i_req    (w_req),
`ifdef ARB_RR_EN
    .i_last_g (r_last_g),
`endif
    .o_gnt    (w_gnt)
  );

  assign w_grant    = |w_gnt;
  assign w_sel      = w_gnt[1];
  assign w_rready_g = (r_g == MST_M1) ? m1_if.rready : m0_if.rready;
  assign w_beat     = (r_state == DATA) & s_if.rvalid & w_rready_g;
  assign w_err_last = s_if.rlast & (r_beat_cnt != r_arlen);
  assign w_err_id   = s_if.rid[IDS_W-1:IDM_W] != MIDX_W'(r_g);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant)                 w_state_nxt = ADDR;
      ADDR:    if (s_if.arready)            w_state_nxt = DATA;
      DATA:    if (w_beat && s_if.rlast)    w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_g        <= MST_M0;
      r_arid     <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_arburst  <= BURST_FIXED;
      r_beat_cnt <= '0;
      r_prot_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_g        <= w_sel;
        r_arid     <= w_sel ? m1_if.arid    : m0_if.arid;
        r_araddr   <= w_sel ? m1_if.araddr  : m0_if.araddr;
        r_arlen    <= w_sel ? m1_if.arlen   : m0_if.arlen;
        r_arsize   <= w_sel ? m1_if.arsize  : m0_if.arsize;
        r_arburst  <= w_sel ? m1_if.arburst : m0_if.arburst;
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        // A slave overrunning 16 beats must not wrap the count back onto a legal LEN.
        if (r_beat_cnt != 4'hF) begin
          r_beat_cnt <= r_beat_cnt + 4'd1;
        end
        if (w_err_last || w_err_id) begin
          r_prot_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    m0_if.arready = 1'b0;
    m0_if.rid     = '0;
    m0_if.rdata   = '0;
    m0_if.rresp   = '0;
    m0_if.rlast   = 1'b0;
    m0_if.rvalid  = 1'b0;
    m1_if.arready = 1'b0;
    m1_if.rid     = '0;
    m1_if.rdata   = '0;
    m1_if.rresp   = '0;
    m1_if.rlast   = 1'b0;
    m1_if.rvalid  = 1'b0;
    s_if.arid     = '0;
    s_if.araddr   = '0;
    s_if.arlen    = '0;
    s_if.arsize   = '0;
    s_if.arburst  = BURST_FIXED;
    s_if.arvalid  = 1'b0;
    s_if.rready   = 1'b0;
    o_prot_err    = 1'b0;
    // Reset is synchronous, so the state is still stale during the reset cycle; gate it here.
    if (!i_rst) begin
      o_prot_err = r_prot_err;
      case (r_state)
        IDLE: begin
          m0_if.arready = w_gnt[0];
          m1_if.arready = w_gnt[1];
        end
        ADDR: begin
          s_if.arvalid = 1'b1;
          s_if.arid    = mk_sid(r_g, r_arid);
          s_if.araddr  = r_araddr;
          s_if.arlen   = r_arlen;
          s_if.arsize  = r_arsize;
          s_if.arburst = r_arburst;
        end
        DATA: begin
          s_if.rready = w_rready_g;
          if (r_g == MST_M1) begin
            m1_if.rvalid = s_if.rvalid;
            m1_if.rid    = s_if.rid[IDM_W-1:0];
            m1_if.rdata  = s_if.rdata;
            m1_if.rresp  = s_if.rresp;
            m1_if.rlast  = s_if.rlast;
          end else begin
            m0_if.rvalid = s_if.rvalid;
            m0_if.rid    = s_if.rid[IDM_W-1:0];
            m0_if.rdata  = s_if.rdata;
            m0_if.rresp  = s_if.rresp;
            m0_if.rlast  = s_if.rlast;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: stimulus pushes expected AR/R traffic into queues,
// a negedge monitor pops and compares whenever the DUT completes a handshake.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prot_err;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ID_W(IDM_W)) m0 ();
  axi_rd_arbiter_if #(.ID_W(IDM_W)) m1 ();
  axi_rd_arbiter_if #(.ID_W(IDS_W)) s ();

  axi_rd_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .m0_if      (m0),
    .m1_if      (m1),
    .s_if       (s),
    .o_prot_err (prot_err)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } r_exp_t;

  ar_exp_t q_ar[$];
  r_exp_t  q_r0[$];
  r_exp_t  q_r1[$];
  ar_exp_t mon_ar;
  r_exp_t  mon_r;
  int      n_chk = 0;
  int      n_err = 0;
  logic    rr_ph;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: event observed, expected none", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (m0.rvalid && m1.rvalid) note_fail("both_rvalid");
      if (s.arvalid && s.arready) begin
        if (q_ar.size() == 0) note_fail("ar_unexpected");
        else begin
          mon_ar = q_ar.pop_front();
          chk("ar_id",   64'(s.arid),   64'(mon_ar.id));
          chk("ar_addr", 64'(s.araddr), 64'(mon_ar.addr));
          chk("ar_len",  64'(s.arlen),  64'(mon_ar.len));
        end
      end
      if (m0.rvalid && m0.rready) begin
        if (q_r0.size() == 0) note_fail("r_m0_unexpected");
        else begin
          mon_r = q_r0.pop_front();
          chk("r_m0_id",   64'(m0.rid),   64'(mon_r.id));
          chk("r_m0_data", 64'(m0.rdata), 64'(mon_r.data));
          chk("r_m0_last", 64'(m0.rlast), 64'(mon_r.last));
        end
      end
      if (m1.rvalid && m1.rready) begin
        if (q_r1.size() == 0) note_fail("r_m1_unexpected");
        else begin
          mon_r = q_r1.pop_front();
          chk("r_m1_id",   64'(m1.rid),   64'(mon_r.id));
          chk("r_m1_data", 64'(m1.rdata), 64'(mon_r.data));
          chk("r_m1_last", 64'(m1.rlast), 64'(mon_r.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input int m, input logic v, input logic [3:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    if (m == 0) begin
      m0.arvalid = v; m0.arid = id; m0.araddr = addr; m0.arlen = len;
    end else begin
      m1.arvalid = v; m1.arid = id; m1.araddr = addr; m1.arlen = len;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arready_m0"}, 64'(m0.arready), 64'd0);
    chk({tag, "_arready_m1"}, 64'(m1.arready), 64'd0);
    chk({tag, "_arvalid_s"},  64'(s.arvalid),  64'd0);
    chk({tag, "_arid_s"},     64'(s.arid),     64'd0);
    chk({tag, "_rready_s"},   64'(s.rready),   64'd0);
    chk({tag, "_rvalid_m0"},  64'(m0.rvalid),  64'd0);
    chk({tag, "_rdata_m0"},   64'(m0.rdata),   64'd0);
    chk({tag, "_rvalid_m1"},  64'(m1.rvalid),  64'd0);
    chk({tag, "_prot_err"},   64'(prot_err),   64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst");
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int g, output int waited);
    g = -1;
    waited = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m0.arready && m1.arready) note_fail("double_grant");
      if (m1.arready) g = 1;
      else if (m0.arready) g = 0;
      if (g >= 0) break;
      waited++;
      tick();
    end
    if (g < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL grant_timeout: no ARREADY within 16 cycles, expected a grant");
    end
  endtask

  // Waits for the grant, records the expected slave AR, and confirms ARVALID_S one cycle later.
  task automatic grant_and_issue(input int exp_m, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input int exp_wait, input bit drop);
    int g;
    int w;
    wait_grant(g, w);
    chk("grant_master", 64'(g), 64'(exp_m));
    chk("grant_wait",   64'(w), 64'(exp_wait));
    q_ar.push_back('{id: {4'(exp_m), id}, addr: addr, len: len});
    tick();
    if (drop) set_ar(exp_m, 1'b0, 4'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("arvalid_s_latency", 64'(s.arvalid), 64'd1);
  endtask

  // Slave returns n beats; bp toggles the granted master's RREADY every cycle.
  task automatic beats(input int m, input logic [7:0] rid, input int n, input int last_at, input bit bp);
    r_exp_t e;
    logic   accepted;
    rr_ph = 1'b1;
    tick();
    for (int b = 0; b < n; b++) begin
      s.rvalid = 1'b1;
      s.rid    = rid;
      s.rdata  = {16'hD0D0, 8'(m), 8'(b)};
      s.rresp  = 2'b00;
      s.rlast  = (b == last_at);
      e = '{id: rid[3:0], data: {16'hD0D0, 8'(m), 8'(b)}, last: (b == last_at)};
      if (m == 0) q_r0.push_back(e);
      else q_r1.push_back(e);
      for (int c = 0; c < 4; c++) begin
        if (m == 0) begin
          m0.rready = rr_ph; m1.rready = ~rr_ph;
        end else begin
          m1.rready = rr_ph; m0.rready = ~rr_ph;
        end
        @(negedge clk);
        chk("rready_s_mirror", 64'(s.rready), 64'(rr_ph));
        tick();
        accepted = rr_ph;
        if (bp) rr_ph = ~rr_ph;
        if (accepted) break;
      end
    end
    s.rvalid = 1'b0;
    s.rlast  = 1'b0;
  endtask

  task automatic chk_ar_hold();
    chk("stall_arvalid_s", 64'(s.arvalid),  64'd1);
    chk("stall_araddr_s",  64'(s.araddr),   64'h3000);
    chk("stall_arid_s",    64'(s.arid),     64'h12);
    chk("stall_arready_m1", 64'(m1.arready), 64'd0);
    chk("stall_arready_m0", 64'(m0.arready), 64'd0);
  endtask

  initial begin
    #200000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    int em;
    int exp_seq[3];
`ifdef ARB_RR_EN
    exp_seq = '{1, 0, 1};
`else
    exp_seq = '{1, 1, 1};
`endif
    m0.arvalid = 1'b0; m0.arid = '0; m0.araddr = '0; m0.arlen = '0;
    m0.arsize = 3'd2; m0.arburst = BURST_INCR; m0.rready = 1'b0;
    m1.arvalid = 1'b0; m1.arid = '0; m1.araddr = '0; m1.arlen = '0;
    m1.arsize = 3'd2; m1.arburst = BURST_INCR; m1.rready = 1'b0;
    s.arready = 1'b1; s.rvalid = 1'b0; s.rid = '0; s.rdata = '0; s.rresp = '0; s.rlast = 1'b0;

    // Reset with activity on the inputs: every output must stay 0.
    rst = 1'b1;
    tick();
    m0.arvalid = 1'b1; s.rvalid = 1'b1; m0.rready = 1'b1;
    @(negedge clk);
    chk_zero("init");
    tick();
    m0.arvalid = 1'b0; s.rvalid = 1'b0; m0.rready = 1'b0;
    rst = 1'b0;

    // M0 single read
    set_ar(0, 1'b1, 4'd3, 32'h0000_0100, 4'd0);
    grant_and_issue(0, 4'd3, 32'h0000_0100, 4'd0, 0, 1'b1);
    beats(0, 8'h03, 1, 0, 1'b0);
    chk("single_prot_err", 64'(prot_err), 64'd0);

    // M1 burst LEN=3 with RREADY toggling
    set_ar(1, 1'b1, 4'd9, 32'h0000_2000, 4'd3);
    grant_and_issue(1, 4'd9, 32'h0000_2000, 4'd3, 0, 1'b1);
    beats(1, 8'h19, 4, 3, 1'b1);
    chk("burst_prot_err", 64'(prot_err), 64'd0);

    // ARREADY_S low for 5 cycles; M0 arrives meanwhile and must wait
    s.arready = 1'b0;
    set_ar(1, 1'b1, 4'd2, 32'h0000_3000, 4'd0);
    grant_and_issue(1, 4'd2, 32'h0000_3000, 4'd0, 0, 1'b1);
    set_ar(0, 1'b1, 4'd4, 32'h0000_4000, 4'd0);
    #1;
    chk_ar_hold();
    for (int i = 1; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk_ar_hold();
    end
    tick();
    s.arready = 1'b1;
    beats(1, 8'h12, 1, 0, 1'b0);
    grant_and_issue(0, 4'd4, 32'h0000_4000, 4'd0, 0, 1'b1);
    beats(0, 8'h04, 1, 0, 1'b0);

    // Early RLAST on beat 2 of LEN=3, then an immediate grant proves the return to IDLE
    set_ar(1, 1'b1, 4'd6, 32'h0000_5000, 4'd3);
    grant_and_issue(1, 4'd6, 32'h0000_5000, 4'd3, 0, 1'b1);
    beats(1, 8'h16, 2, 1, 1'b0);
    chk("early_last_prot_err", 64'(prot_err), 64'd1);
    set_ar(0, 1'b1, 4'd1, 32'h0000_5100, 4'd0);
    grant_and_issue(0, 4'd1, 32'h0000_5100, 4'd0, 0, 1'b1);
    beats(0, 8'h01, 1, 0, 1'b0);
    chk("prot_err_sticky", 64'(prot_err), 64'd1);

    // Wrong master index in RID while M0 granted; beat still reaches M0
    do_reset();
    chk("after_rst_prot_err", 64'(prot_err), 64'd0);
    set_ar(0, 1'b1, 4'd5, 32'h0000_A000, 4'd0);
    grant_and_issue(0, 4'd5, 32'h0000_A000, 4'd0, 0, 1'b1);
    beats(0, 8'h15, 1, 0, 1'b0);
    chk("bad_rid_prot_err", 64'(prot_err), 64'd1);

    // Reset one cycle after beat 1 of 4
    set_ar(0, 1'b1, 4'd7, 32'h0000_6000, 4'd3);
    grant_and_issue(0, 4'd7, 32'h0000_6000, 4'd3, 0, 1'b1);
    beats(0, 8'h07, 1, 99, 1'b0);
    rst = 1'b1;
    s.rvalid = 1'b1; s.rid = 8'h07; s.rdata = 32'hDEAD_BEEF; s.rlast = 1'b0;
    @(negedge clk);
    chk_zero("mid_rst");
    tick();
    rst = 1'b0;
    s.rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_prot_err", 64'(prot_err), 64'd0);
    chk("post_rst_rvalid_m0", 64'(m0.rvalid), 64'd0);
    chk("post_rst_rready_s", 64'(s.rready), 64'd0);
    tick();
    set_ar(0, 1'b1, 4'd8, 32'h0000_7000, 4'd0);
    grant_and_issue(0, 4'd8, 32'h0000_7000, 4'd0, 0, 1'b1);
    beats(0, 8'h08, 1, 0, 1'b0);
    chk("post_rst_read_prot_err", 64'(prot_err), 64'd0);

    // Both masters requesting every cycle, LEN=1
    do_reset();
    set_ar(0, 1'b1, 4'hA, 32'h0000_8000, 4'd1);
    set_ar(1, 1'b1, 4'hB, 32'h0000_9000, 4'd1);
    for (int k = 0; k < 3; k++) begin
      em = exp_seq[k];
      grant_and_issue(em, (em != 0) ? 4'hB : 4'hA, (em != 0) ? 32'h0000_9000 : 32'h0000_8000,
                      4'd1, 0, 1'b0);
      beats(em, {4'(em), (em != 0) ? 4'hB : 4'hA}, 2, 1, 1'b0);
    end
    set_ar(0, 1'b0, 4'd0, 32'd0, 4'd0);
    set_ar(1, 1'b0, 4'd0, 32'd0, 4'd0);

    repeat (3) tick();
    chk("q_ar_drained", 64'(q_ar.size()), 64'd0);
    chk("q_r0_drained", 64'(q_r0.size()), 64'd0);
    chk("q_r1_drained", 64'(q_r1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
